// File: rtl/myuart_apb_master.sv
// APB3 initiator: turns single valid/ready commands into SETUP/ACCESS transfers
// and returns read data and error status on a valid/ready response channel.
module myuart_apb_master #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk_i,
    input  logic                  preset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;
    logic [1:0]              rsp_err_nxt;

    assign cmd_ready_o = (state == IDLE);

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 2'b00;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            psel_o      <= psel_nxt;
            penable_o   <= penable_nxt;
            pwrite_o    <= pwrite_nxt;
            paddr_o     <= paddr_nxt;
            pwdata_o    <= pwdata_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            rsp_err_o   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        psel_nxt      = psel_o;
        penable_nxt   = penable_o;
        pwrite_nxt    = pwrite_o;
        paddr_nxt     = paddr_o;
        pwdata_nxt    = pwdata_o;
        rsp_valid_nxt = rsp_valid_o;
        rsp_rdata_nxt = rsp_rdata_o;
        rsp_err_nxt   = rsp_err_o;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    pwrite_nxt = cmd_write_i;
                    paddr_nxt  = cmd_addr_i;
                    pwdata_nxt = cmd_wdata_i;
                    psel_nxt   = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // prdata/pslverr are only meaningful on the completing edge
                if (pready_i) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_rdata_nxt = pwrite_o ? '0 : prdata_i;
                    rsp_err_nxt   = pslverr_i ? 2'b01 : 2'b00;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (cnt == CNT_LAST) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 2'b10;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_myuart_apb_master.sv
// Scoreboard bench for myuart_apb_master: random commands against an APB slave
// model with planned wait states/errors; responses checked from a queue.
module tb_myuart_apb_master;
    localparam int TIMEOUT = 16;

    logic        pclk, preset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    typedef struct {
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        int          waits;
        logic [31:0] rd;
        logic        se;
        int          len;
    } plan_t;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stall_n = 0;

    myuart_apb_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .pclk_i(pclk), .preset_n_i(preset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave model: plays back the planned wait count, data and error
    plan_t cur;
    bit    active = 0;
    int    acc = 0;
    always @(negedge pclk) begin
        if (!preset_n) begin
            active = 0; acc = 0; pready = 1'b0;
        end else if (psel && !penable) begin
            if (plan_q.size() == 0) begin
                chk("unexpected_setup", 1, 0);
                active = 0;
            end else begin
                cur = plan_q.pop_front();
                chk("setup_paddr", paddr, cur.a);
                chk("setup_pwrite", pwrite, cur.w);
                chk("setup_pwdata", pwdata, cur.d);
                active = 1;
                acc = 0;
            end
            pready = $urandom; prdata = $urandom; pslverr = $urandom;
        end else if (psel && penable) begin
            chk("access_after_setup", active, 1);
            chk("access_paddr_stable", paddr, cur.a);
            chk("access_pwdata_stable", pwdata, cur.d);
            if (acc == cur.waits) begin
                pready = 1'b1; prdata = cur.rd; pslverr = cur.se;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = $urandom;
            end
            acc++;
        end else begin
            if (active) begin
                chk("access_len", acc, cur.len);
                chk("penable_low_at_end", penable, 0);
                chk("rsp_latency", rsp_valid, 1);
                active = 0;
            end
            pready = $urandom; prdata = $urandom; pslverr = $urandom;
        end
    end

    // response monitor: pops the scoreboard on every handshake
    bit          stalled = 0, post_hs = 0;
    logic [31:0] held_rd;
    logic [1:0]  held_err;
    exp_t        e;
    always @(negedge pclk) begin
        if (!preset_n) begin
            stalled = 0; post_hs = 0; rsp_ready = 1'b0;
        end else begin
            if (post_hs) begin
                chk("idle_after_handshake", {rsp_valid, cmd_ready}, 2'b01);
                post_hs = 0;
            end
            if (rsp_valid) begin
                if (stalled) begin
                    chk("hold_rdata", rsp_rdata, held_rd);
                    chk("hold_err", rsp_err, held_err);
                end
                chk("no_accept_in_resp", cmd_ready, 0);
                chk("no_psel_in_resp", psel, 0);
                if (stall_n > 0) begin
                    rsp_ready = 1'b0;
                    stall_n--;
                end else begin
                    rsp_ready = ($urandom % 3) != 0;
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rd);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    stalled = 0;
                    post_hs = 1;
                end else begin
                    stalled = 1; held_rd = rsp_rdata; held_err = rsp_err;
                end
            end else begin
                rsp_ready = $urandom;
                stalled = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input logic se);
        int    n;
        bit    ok;
        plan_t p;
        exp_t  x;
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
            ok = cmd_ready;
            @(posedge pclk);
            n++;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            p.w = w; p.a = a; p.d = d; p.waits = waits; p.rd = rd; p.se = se;
            p.len = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
            plan_q.push_back(p);
            x.rd  = (w || waits >= TIMEOUT) ? 32'h0 : rd;
            x.err = (waits >= TIMEOUT) ? 2'b10 : (se ? 2'b01 : 2'b00);
            exp_q.push_back(x);
            #1;
            chk("psel_after_accept", {psel, penable}, 2'b10);
        end
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge pclk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int waits;
        preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #1;
        chk("reset_apb", {psel, penable, pwrite, paddr, rsp_valid, rsp_err}, 0);
        chk("reset_data", {pwdata, rsp_rdata}, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;

        issue(1'b1, 6'h04, 32'h0000_0272, 0, 32'h1234_5678, 1'b0);
        issue(1'b0, 6'h08, 32'h0, 3, 32'h0000_00F0, 1'b0);
        issue(1'b1, 6'h10, 32'h0010_3E01, 1, 32'h0, 1'b1);
        issue(1'b0, 6'h0C, 32'h0, 0, 32'hA5A5_5A5A, 1'b0);
        issue(1'b0, 6'h14, 32'h0, TIMEOUT, 32'hFFFF_FFFF, 1'b0);
        issue(1'b0, 6'h18, 32'h0, TIMEOUT - 1, 32'h0BAD_CAFE, 1'b1);
        drain();
        stall_n = 5;
        issue(1'b0, 6'h1C, 32'h0, 2, 32'h1357_9BDF, 1'b0);
        drain();

        for (int i = 0; i < 60; i++) begin
            waits = ($urandom % 8 == 0) ? TIMEOUT - 1 + int'($urandom % 3) : int'($urandom % 5);
            issue($urandom, $urandom, $urandom, waits, $urandom, ($urandom % 4) == 0);
            for (int g = int'($urandom % 3); g > 0; g--) begin
                @(negedge pclk);
                // a valid pulse while busy must never start a transfer
                if (!cmd_ready) cmd_valid = $urandom;
                @(negedge pclk);
                cmd_valid = 1'b0;
            end
        end
        drain();

        issue(1'b0, 6'h20, 32'h0, 40, 32'hDEAD_BEEF, 1'b0);
        repeat (3) @(posedge pclk);
        #2 preset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {psel, penable, rsp_valid}, 3'b000);
        chk("async_reset_cmd_ready", cmd_ready, 1);
        chk("async_reset_paddr", paddr, 0);
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        #1;
        chk("post_reset_cmd_ready", cmd_ready, 1);
        issue(1'b0, 6'h24, 32'h0, 1, 32'hC0FF_EE00, 1'b0);
        drain();
        repeat (4) @(posedge pclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
